nrf_rx_controller: RTL

//  Sequencing FSM for the nRF SPI datapath: polls STATUS, clears RX_DR, checks FIFO_STATUS,

---
 rtl/nrf_rx_controller.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nrf_rx_controller.sv
// Receive-side sequencer for the nRF SPI datapath: polls STATUS, clears RX_DR, checks the RX FIFO,
// reads the payload width and burst-reads the payload, driving every datapath strobe.
module nrf_rx_controller #(
    parameter logic [7:0] CMD_NOP      = 8'hFF,
    parameter logic [7:0] CMD_W_STATUS = 8'h27,
    parameter logic [7:0] VAL_CLR_RXDR = 8'h40,
    parameter logic [7:0] CMD_R_FIFO   = 8'h17,
    parameter logic [7:0] CMD_R_PL_WID = 8'h60,
    parameter logic [7:0] CMD_R_PL     = 8'h61,
    parameter logic [7:0] DUMMY_BYTE   = 8'hFF,
    parameter int         CSN_GAP      = 2,
    parameter int         TIMEOUT      = 4096
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_TX_Ready,
    input  logic       i_RX_DV,
    input  logic       i_RX_DR_Set,
    input  logic       i_FIFO_Empty,
    input  logic       i_Eqz,
    input  logic       i_Done_Sleep,
    output logic [7:0] o_Data,
    output logic       o_SPI_Csn,
    output logic       o_Load_TX,
    output logic       o_TX_DV,
    output logic       o_Load_RX,
    output logic       o_Load_Data_Size,
    output logic       o_Incr_Count,
    output logic       o_Load_Mem,
    output logic       o_Latch_Output,
    output logic       o_Start_Sleep,
    output logic       o_Busy,
    output logic       o_Error,
    output logic [4:0] o_Dbg_State
);

    // Handshake: a byte is handed over only while i_TX_Ready is high (o_Load_TX then o_TX_DV,
    // one cycle each); the reply is accepted only on an i_RX_DV pulse seen in WAIT_RX.
    typedef enum logic [4:0] {
        S_IDLE, S_GAP, S_WAIT_RDY, S_LOAD, S_GO, S_WAIT_RX, S_CAP,
        S_CHK_DR, S_CHK_FIFO, S_SIZE, S_CHK_EQZ, S_STORE, S_LATCH,
        S_SLEEP, S_SLEEP_WAIT
    } state_t;

    typedef enum logic [2:0] {
        T_STAT, T_CLR, T_FIFO, T_WID, T_PL_CMD, T_PL_BYTE
    } txn_t;

    localparam int CNT_W = $clog2(TIMEOUT + CSN_GAP + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CSN_GAP - 1);

    state_t           state;
    txn_t             txn;
    logic             byte_idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       tx_byte;
    logic             last_byte;

    assign o_Dbg_State = state;

    // Byte to send and whether it closes the current transaction.
    always_comb begin
        tx_byte   = DUMMY_BYTE;
        last_byte = 1'b1;
        case (txn)
            T_STAT:    tx_byte = CMD_NOP;
            T_CLR: begin
                tx_byte   = byte_idx ? VAL_CLR_RXDR : CMD_W_STATUS;
                last_byte = byte_idx;
            end
            T_FIFO: begin
                tx_byte   = byte_idx ? DUMMY_BYTE : CMD_R_FIFO;
                last_byte = byte_idx;
            end
            T_WID: begin
                tx_byte   = byte_idx ? DUMMY_BYTE : CMD_R_PL_WID;
                last_byte = byte_idx;
            end
            T_PL_CMD:  tx_byte = CMD_R_PL;
            default:   tx_byte = DUMMY_BYTE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state            <= S_IDLE;
            txn              <= T_STAT;
            byte_idx         <= 1'b0;
            cnt              <= '0;
            o_Data           <= 8'h00;
            o_SPI_Csn        <= 1'b1;
            o_Load_TX        <= 1'b0;
            o_TX_DV          <= 1'b0;
            o_Load_RX        <= 1'b0;
            o_Load_Data_Size <= 1'b0;
            o_Incr_Count     <= 1'b0;
            o_Load_Mem       <= 1'b0;
            o_Latch_Output   <= 1'b0;
            o_Start_Sleep    <= 1'b0;
            o_Busy           <= 1'b0;
            o_Error          <= 1'b0;
        end else begin
            o_Load_TX        <= 1'b0;
            o_TX_DV          <= 1'b0;
            o_Load_RX        <= 1'b0;
            o_Load_Data_Size <= 1'b0;
            o_Incr_Count     <= 1'b0;
            o_Load_Mem       <= 1'b0;
            o_Latch_Output   <= 1'b0;
            o_Start_Sleep    <= 1'b0;
            o_Error          <= 1'b0;
            cnt              <= '0;
            case (state)
                S_IDLE: begin
                    if (i_Enable) begin
                        state    <= S_GAP;
                        txn      <= T_STAT;
                        byte_idx <= 1'b0;
                        o_Busy   <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) state <= S_WAIT_RDY;
                    else                 cnt   <= cnt + 1'b1;
                end
                S_WAIT_RDY: begin
                    if (i_TX_Ready) begin
                        state     <= S_LOAD;
                        o_Load_TX <= 1'b1;
                        o_Data    <= tx_byte;
                        o_SPI_Csn <= 1'b0;
                    end else if (cnt == TMO_LAST) begin
                        state         <= S_SLEEP;
                        o_Start_Sleep <= 1'b1;
                        o_Error       <= 1'b1;
                        o_SPI_Csn     <= 1'b1;
                        byte_idx      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    state   <= S_GO;
                    o_TX_DV <= 1'b1;
                end
                S_GO: state <= S_WAIT_RX;
                S_WAIT_RX: begin
                    if (i_RX_DV) begin
                        state     <= S_CAP;
                        o_Load_RX <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        state         <= S_SLEEP;
                        o_Start_Sleep <= 1'b1;
                        o_Error       <= 1'b1;
                        o_SPI_Csn     <= 1'b1;
                        byte_idx      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAP: begin
                    if (!last_byte) begin
                        byte_idx <= 1'b1;
                        state    <= S_WAIT_RDY;
                    end else begin
                        byte_idx <= 1'b0;
                        case (txn)
                            T_STAT: begin
                                o_SPI_Csn <= 1'b1;
                                state     <= S_CHK_DR;
                            end
                            T_CLR: begin
                                o_SPI_Csn <= 1'b1;
                                txn       <= T_FIFO;
                                state     <= S_GAP;
                            end
                            T_FIFO: begin
                                o_SPI_Csn <= 1'b1;
                                state     <= S_CHK_FIFO;
                            end
                            T_WID: begin
                                o_SPI_Csn        <= 1'b1;
                                o_Load_Data_Size <= 1'b1;
                                state            <= S_SIZE;
                            end
                            T_PL_BYTE: begin
                                o_Incr_Count <= 1'b1;
                                o_Load_Mem   <= 1'b1;
                                state        <= S_STORE;
                            end
                            default: state <= S_CHK_EQZ;
                        endcase
                    end
                end
                S_CHK_DR: begin
                    if (!i_RX_DR_Set) begin
                        state         <= S_SLEEP;
                        o_Start_Sleep <= 1'b1;
                    end else begin
                        txn   <= T_CLR;
                        state <= S_GAP;
                    end
                end
                S_CHK_FIFO: begin
                    if (i_FIFO_Empty) begin
                        state         <= S_SLEEP;
                        o_Start_Sleep <= 1'b1;
                    end else begin
                        txn   <= T_WID;
                        state <= S_GAP;
                    end
                end
                S_SIZE: begin
                    txn   <= T_PL_CMD;
                    state <= S_GAP;
                end
                // Payload bytes keep CSN low; they reuse the byte sub-sequence without a gap.
                S_CHK_EQZ: begin
                    if (i_Eqz) begin
                        state          <= S_LATCH;
                        o_Latch_Output <= 1'b1;
                    end else begin
                        txn   <= T_PL_BYTE;
                        state <= S_WAIT_RDY;
                    end
                end
                S_STORE: state <= S_CHK_EQZ;
                S_LATCH: begin
                    o_SPI_Csn     <= 1'b1;
                    o_Start_Sleep <= 1'b1;
                    state         <= S_SLEEP;
                end
                S_SLEEP: state <= S_SLEEP_WAIT;
                S_SLEEP_WAIT: begin
                    if (i_Done_Sleep) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
